// File: rtl/divider_arbiter_pkg.sv
// Shared types and widths for the divider arbiter.
// Holds the FSM state enum, the divider operand/result widths, and the RUN counter width.
package divider_arbiter_pkg;

  // Divider operand and result widths.
  localparam int unsigned AWidth   = 22;
  localparam int unsigned BWidth   = 8;
  localparam int unsigned QWidth   = 16;

  // RUN cycle counter width; TIMEOUT must fit in it.
  localparam int unsigned CntWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StClr,
    StRun,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   i_req   : request vector, one bit per requester
//   i_last  : index of the last granted requester; search starts one above it
//   o_gnt   : one-hot grant (all zero when no request)
//   o_idx   : index of the granted requester
//   o_valid : at least one request present
module rr_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_last,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  logic [IdxW-1:0] w_k;

  // Walk offsets 1..N from the last grant so the last grantee is checked last.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      w_k = IdxW'((32'(i_last) + off) % N);
      if (!o_valid && i_req[w_k]) begin
        o_valid    = 1'b1;
        o_idx      = w_k;
        o_gnt[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one external divider_22 among NREQ requesters.
// A round-robin winner is granted in IDLE, the divider is cleared for one cycle (CLR),
// run until done or timeout (RUN), and the result is returned in a one-cycle RESP pulse.
// All outputs are registered.
// Ports:
//   clock, rst_n              : clock, asynchronous active-low reset
//   i_req_valid/a/b           : per-requester request and flattened signed operands
//   o_req_ready               : one-cycle accept pulse to the winner (during CLR)
//   o_rsp_valid/q/r/err       : one-cycle result pulse to the owner, result held afterwards
//   o_busy                    : high outside IDLE
//   o_div_rst_n/start/a/b     : divider control and operands
//   i_div_done/q/r            : divider done flag and results
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*AWidth-1:0] i_req_a,
  input  logic [NREQ*BWidth-1:0] i_req_b,
  output logic [NREQ-1:0]        o_req_ready,
  output logic [NREQ-1:0]        o_rsp_valid,
  output logic [QWidth-1:0]      o_rsp_q,
  output logic [QWidth-1:0]      o_rsp_r,
  output logic                   o_rsp_err,
  output logic                   o_busy,
  output logic                   o_div_rst_n,
  output logic                   o_div_start,
  output logic [AWidth-1:0]      o_div_a,
  output logic [BWidth-1:0]      o_div_b,
  input  logic                   i_div_done,
  input  logic [QWidth-1:0]      i_div_q,
  input  logic [QWidth-1:0]      i_div_r
);

  localparam int unsigned       IdxW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IdxW-1:0]   LastInit    = IdxW'(NREQ - 1);
  // Exit on the cycle the counter would step to TIMEOUT.
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT - 1);

  // Unpacked operand views.
  logic [AWidth-1:0] w_req_a [NREQ];
  logic [BWidth-1:0] w_req_b [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_req_a[k] = i_req_a[k*AWidth +: AWidth];
    assign w_req_b[k] = i_req_b[k*BWidth +: BWidth];
  end

  // State registers.
  state_e              r_state;
  logic [IdxW-1:0]     r_last;
  logic [IdxW-1:0]     r_win;
  logic [CntWidth-1:0] r_cnt;
  logic [NREQ-1:0]     r_req_ready;
  logic [NREQ-1:0]     r_rsp_valid;
  logic [QWidth-1:0]   r_rsp_q;
  logic [QWidth-1:0]   r_rsp_r;
  logic                r_rsp_err;
  logic                r_busy;
  logic                r_div_rst_n;
  logic                r_div_start;
  logic [AWidth-1:0]   r_div_a;
  logic [BWidth-1:0]   r_div_b;

  // Next-state values.
  state_e              w_state_d;
  logic [IdxW-1:0]     w_last_d;
  logic [IdxW-1:0]     w_win_d;
  logic [CntWidth-1:0] w_cnt_d;
  logic [NREQ-1:0]     w_req_ready_d;
  logic [NREQ-1:0]     w_rsp_valid_d;
  logic [QWidth-1:0]   w_rsp_q_d;
  logic [QWidth-1:0]   w_rsp_r_d;
  logic                w_rsp_err_d;
  logic                w_busy_d;
  logic                w_div_rst_n_d;
  logic                w_div_start_d;
  logic [AWidth-1:0]   w_div_a_d;
  logic [BWidth-1:0]   w_div_b_d;

  // Arbiter outputs.
  logic [NREQ-1:0] w_gnt;
  logic [IdxW-1:0] w_gnt_idx;
  logic            w_gnt_valid;
  logic [NREQ-1:0] w_win_onehot;

  rr_arbiter #(
    .N    (NREQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  always_comb begin
    w_win_onehot        = '0;
    w_win_onehot[r_win] = 1'b1;
  end

  always_comb begin
    w_state_d     = r_state;
    w_last_d      = r_last;
    w_win_d       = r_win;
    w_cnt_d       = r_cnt;
    w_req_ready_d = '0;
    w_rsp_valid_d = '0;
    w_rsp_q_d     = r_rsp_q;
    w_rsp_r_d     = r_rsp_r;
    w_rsp_err_d   = r_rsp_err;
    w_div_rst_n_d = 1'b1;
    w_div_start_d = 1'b0;
    w_div_a_d     = r_div_a;
    w_div_b_d     = r_div_b;

    unique case (r_state)
      StIdle: begin
        if (w_gnt_valid) begin
          w_state_d     = StClr;
          w_win_d       = w_gnt_idx;
          w_last_d      = w_gnt_idx;
          w_div_a_d     = w_req_a[w_gnt_idx];
          w_div_b_d     = w_req_b[w_gnt_idx];
          // Ready pulse and divider clear both appear in the CLR cycle.
          w_req_ready_d = w_gnt;
          w_div_rst_n_d = 1'b0;
        end
      end
      StClr: begin
        if (r_div_b == '0) begin
          // Divide-by-zero never starts the divider.
          w_state_d     = StResp;
          w_rsp_valid_d = w_win_onehot;
          w_rsp_q_d     = '0;
          w_rsp_r_d     = '0;
          w_rsp_err_d   = 1'b1;
        end else begin
          w_state_d     = StRun;
          w_div_start_d = 1'b1;
          w_cnt_d       = '0;
        end
      end
      StRun: begin
        w_div_start_d = 1'b1;
        if (i_div_done) begin
          w_state_d     = StResp;
          w_div_start_d = 1'b0;
          w_rsp_valid_d = w_win_onehot;
          w_rsp_q_d     = i_div_q;
          w_rsp_r_d     = i_div_r;
          w_rsp_err_d   = 1'b0;
        end else if (r_cnt == TimeoutLast) begin
          w_state_d     = StResp;
          w_div_start_d = 1'b0;
          w_rsp_valid_d = w_win_onehot;
          w_rsp_q_d     = '0;
          w_rsp_r_d     = '0;
          w_rsp_err_d   = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_last      <= LastInit;
      r_win       <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_div_rst_n <= 1'b0;
      r_div_start <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_last      <= w_last_d;
      r_win       <= w_win_d;
      r_cnt       <= w_cnt_d;
      r_req_ready <= w_req_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_q     <= w_rsp_q_d;
      r_rsp_r     <= w_rsp_r_d;
      r_rsp_err   <= w_rsp_err_d;
      r_busy      <= w_busy_d;
      r_div_rst_n <= w_div_rst_n_d;
      r_div_start <= w_div_start_d;
      r_div_a     <= w_div_a_d;
      r_div_b     <= w_div_b_d;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_q     = r_rsp_q;
  assign o_rsp_r     = r_rsp_r;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = r_busy;
  assign o_div_rst_n = r_div_rst_n;
  assign o_div_start = r_div_start;
  assign o_div_a     = r_div_a;
  assign o_div_b     = r_div_b;

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter with a behavioural divider model and a result
// scoreboard.
module tb_divider_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 200;

  logic              clock = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*22-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_q;
  logic [15:0]       rsp_r;
  logic              rsp_err;
  logic              busy;
  logic              div_rst_n;
  logic              div_start;
  logic [21:0]       div_a;
  logic [7:0]        div_b;
  logic              div_done;
  logic [15:0]       div_q;
  logic [15:0]       div_r;

  always #5 clock = ~clock;

  divider_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_q     (rsp_q),
    .o_rsp_r     (rsp_r),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy),
    .o_div_rst_n (div_rst_n),
    .o_div_start (div_start),
    .o_div_a     (div_a),
    .o_div_b     (div_b),
    .i_div_done  (div_done),
    .i_div_q     (div_q),
    .i_div_r     (div_r)
  );

  // Divider model: counts start cycles since the last clear; m_done_at = 0 never finishes.
  int          m_done_at = 10;
  int          m_cnt     = 0;
  logic [15:0] m_q       = 16'h1234;
  logic [15:0] m_r       = 16'h0005;
  int          start_cnt = 0;
  int          multi_hot = 0;

  always @(posedge clock) begin
    if (!div_rst_n) m_cnt <= 0;
    else if (div_start) m_cnt <= m_cnt + 1;
    if (div_start) start_cnt <= start_cnt + 1;
  end

  assign div_done = (m_done_at != 0) && div_rst_n && div_start && (m_cnt == m_done_at - 1);
  assign div_q    = m_q;
  assign div_r    = m_r;

  always @(negedge clock) begin
    if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) multi_hot = multi_hot + 1;
  end

  typedef struct {
    int          idx;
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic set_req(input int k, input logic [21:0] a, input logic [7:0] b);
    req_a[k*22 +: 22] = a;
    req_b[k*8 +: 8]   = b;
    req_valid[k]      = 1'b1;
  endtask

  task automatic wait_ready(input int limit, output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) idx = j;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int limit, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (rsp_valid != '0) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clock);
    total++;
    if ({req_ready, rsp_valid, busy, div_start, div_rst_n, rsp_err} !== '0 ||
        {rsp_q, rsp_r, div_a, div_b} !== '0) begin
      bad++;
      $display("FAIL reset_values: got rdy=%b vld=%b busy=%b st=%b drn=%b q=%h r=%h a=%h b=%h want all 0",
               req_ready, rsp_valid, busy, div_start, div_rst_n, rsp_q, rsp_r, div_a, div_b);
    end
    rst_n = 1'b1;
    @(negedge clock);
    total++;
    if (div_rst_n !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got div_rst_n=%b busy=%b want 1 0", div_rst_n, busy);
    end
  endtask

  task automatic test_fairness();
    int   idx, lat;
    bit   ok;
    exp_t e;
    m_done_at = 3;
    m_q       = 16'h0A0A;
    m_r       = 16'h0001;
    for (int k = 0; k < NREQ; k++) set_req(k, 22'(1000 + k), 8'(k + 1));
    for (int n = 0; n < 5; n++) begin
      wait_ready(40, idx, ok);
      total++;
      if (!ok || idx != n % NREQ) begin
        bad++;
        $display("FAIL fair_grant%0d: got idx=%0d (ok=%0d) want %0d", n, idx, ok, n % NREQ);
      end
      total++;
      if (div_rst_n !== 1'b0 || div_a !== 22'(1000 + n % NREQ)) begin
        bad++;
        $display("FAIL fair_clr%0d: got div_rst_n=%b div_a=%0d want 0 %0d",
                 n, div_rst_n, div_a, 1000 + n % NREQ);
      end
      sb.push_back('{n % NREQ, m_q, m_r, 1'b0});
      if (n == 4) req_valid = '0;
      @(negedge clock);
      total++;
      if (div_rst_n !== 1'b1) begin
        bad++;
        $display("FAIL fair_clr_len%0d: got div_rst_n=%b want 1", n, div_rst_n);
      end
      wait_rsp(40, lat, ok);
      e = sb.pop_front();
      total++;
      if (!ok || rsp_valid !== 4'(1 << e.idx) || rsp_q !== e.q || rsp_r !== e.r ||
          rsp_err !== e.err) begin
        bad++;
        $display("FAIL fair_rsp%0d: got vld=%b q=%h r=%h err=%b want vld=%b q=%h r=%h err=%b",
                 n, rsp_valid, rsp_q, rsp_r, rsp_err, 4'(1 << e.idx), e.q, e.r, e.err);
      end
    end
  endtask

  task automatic test_single();
    int   idx, lat;
    bit   ok;
    exp_t e;
    m_done_at = 10;
    m_q       = 16'h1234;
    m_r       = 16'h0005;
    set_req(0, 22'd100, 8'd5);
    sb.push_back('{0, 16'h1234, 16'h0005, 1'b0});
    wait_ready(20, idx, ok);
    total++;
    if (!ok || req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_grant: got ready=%b want 0001", req_ready);
    end
    req_valid[0] = 1'b0;
    total++;
    if (div_a !== 22'd100 || div_b !== 8'd5) begin
      bad++;
      $display("FAIL single_operands: got a=%0d b=%0d want 100 5", div_a, div_b);
    end
    wait_rsp(300, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok || lat != 11) begin
      bad++;
      $display("FAIL single_latency: got %0d want 11", lat);
    end
    total++;
    if (rsp_valid !== 4'b0001 || rsp_q !== e.q || rsp_r !== e.r || rsp_err !== e.err) begin
      bad++;
      $display("FAIL single_rsp: got vld=%b q=%h r=%h err=%b want 0001 %h %h %b",
               rsp_valid, rsp_q, rsp_r, rsp_err, e.q, e.r, e.err);
    end
  endtask

  task automatic test_div_zero();
    int   idx, lat, s;
    bit   ok;
    exp_t e;
    s = start_cnt;
    set_req(2, 22'd77, 8'd0);
    sb.push_back('{2, 16'h0000, 16'h0000, 1'b1});
    wait_ready(20, idx, ok);
    total++;
    if (!ok || req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL dz_grant: got ready=%b want 0100", req_ready);
    end
    req_valid[2] = 1'b0;
    wait_rsp(20, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok || lat != 1) begin
      bad++;
      $display("FAIL dz_latency: got %0d want 1", lat);
    end
    total++;
    if (rsp_valid !== 4'b0100 || rsp_q !== e.q || rsp_r !== e.r || rsp_err !== e.err) begin
      bad++;
      $display("FAIL dz_rsp: got vld=%b q=%h r=%h err=%b want 0100 %h %h %b",
               rsp_valid, rsp_q, rsp_r, rsp_err, e.q, e.r, e.err);
    end
    @(negedge clock);
    total++;
    if (start_cnt != s) begin
      bad++;
      $display("FAIL dz_no_start: got %0d start cycles want 0", start_cnt - s);
    end
  endtask

  task automatic test_timeout();
    int   idx, lat;
    bit   ok;
    exp_t e;
    m_done_at = 0;
    set_req(1, 22'd500, 8'd3);
    sb.push_back('{1, 16'h0000, 16'h0000, 1'b1});
    wait_ready(20, idx, ok);
    req_valid[1] = 1'b0;
    wait_rsp(400, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok || lat != TIMEOUT + 1) begin
      bad++;
      $display("FAIL to_latency: got %0d want %0d", lat, TIMEOUT + 1);
    end
    total++;
    if (rsp_valid !== 4'b0010 || rsp_q !== e.q || rsp_r !== e.r || rsp_err !== e.err) begin
      bad++;
      $display("FAIL to_rsp: got vld=%b q=%h r=%h err=%b want 0010 %h %h %b",
               rsp_valid, rsp_q, rsp_r, rsp_err, e.q, e.r, e.err);
    end
    m_done_at = 4;
    m_q       = 16'hBEEF;
    m_r       = 16'h0003;
    set_req(3, 22'd9, 8'd2);
    sb.push_back('{3, 16'hBEEF, 16'h0003, 1'b0});
    wait_ready(20, idx, ok);
    req_valid[3] = 1'b0;
    total++;
    if (!ok || idx != 3) begin
      bad++;
      $display("FAIL after_to_grant: got %0d want 3", idx);
    end
    wait_rsp(40, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok || lat != 5 || rsp_valid !== 4'b1000 || rsp_q !== e.q || rsp_r !== e.r ||
        rsp_err !== e.err) begin
      bad++;
      $display("FAIL after_to_rsp: got lat=%0d vld=%b q=%h r=%h err=%b want 5 1000 %h %h %b",
               lat, rsp_valid, rsp_q, rsp_r, rsp_err, e.q, e.r, e.err);
    end
    @(negedge clock);
    total++;
    if (rsp_valid !== 4'b0000 || rsp_q !== 16'hBEEF || rsp_r !== 16'h0003 || busy !== 1'b0) begin
      bad++;
      $display("FAIL result_hold: got vld=%b q=%h r=%h busy=%b want 0000 beef 0003 0",
               rsp_valid, rsp_q, rsp_r, busy);
    end
  endtask

  task automatic test_drop();
    int   idx, lat;
    bit   ok;
    exp_t e;
    m_done_at = 20;
    m_q       = 16'h5555;
    m_r       = 16'h0002;
    set_req(0, 22'd10, 8'd1);
    sb.push_back('{0, 16'h5555, 16'h0002, 1'b0});
    wait_ready(20, idx, ok);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clock);
    set_req(3, 22'd11, 8'd1);
    repeat (3) @(negedge clock);
    req_valid[3] = 1'b0;
    wait_rsp(40, lat, ok);
    e = sb.pop_front();
    total++;
    if (!ok || rsp_valid !== 4'b0001 || rsp_q !== e.q || rsp_r !== e.r || rsp_err !== e.err) begin
      bad++;
      $display("FAIL drop_rsp: got vld=%b q=%h r=%h err=%b want 0001 %h %h %b",
               rsp_valid, rsp_q, rsp_r, rsp_err, e.q, e.r, e.err);
    end
    wait_ready(10, idx, ok);
    total++;
    if (ok || busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_ignored: got grant=%0d busy=%b want none 0", idx, busy);
    end
  endtask

  task automatic test_reset_run();
    int   idx, lat, seen;
    bit   ok;
    exp_t e;
    m_done_at = 0;
    set_req(2, 22'd1234, 8'd7);
    wait_ready(20, idx, ok);
    req_valid[2] = 1'b0;
    repeat (5) @(negedge clock);
    total++;
    if (busy !== 1'b1 || div_start !== 1'b1) begin
      bad++;
      $display("FAIL rr_in_run: got busy=%b start=%b want 1 1", busy, div_start);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, busy, div_start, div_rst_n, rsp_err} !== '0 ||
        {rsp_q, rsp_r, div_a, div_b} !== '0) begin
      bad++;
      $display("FAIL rr_reset_values: got vld=%b busy=%b st=%b drn=%b q=%h a=%h want all 0",
               rsp_valid, busy, div_start, div_rst_n, rsp_q, div_a);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (rsp_valid != '0) seen++;
    end
    rst_n = 1'b1;
    m_done_at = 2;
    m_q       = 16'h00C3;
    m_r       = 16'h0000;
    set_req(0, 22'd3, 8'd1);
    set_req(1, 22'd4, 8'd1);
    set_req(2, 22'd1234, 8'd7);
    wait_ready(20, idx, ok);
    req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid != '0) begin
        seen++;
        break;
      end
    end
    total++;
    if (!ok || idx != 0) begin
      bad++;
      $display("FAIL rr_first_winner: got %0d want 0", idx);
    end
    total++;
    if (seen != 1 || rsp_valid !== 4'b0001 || rsp_q !== 16'h00C3 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL rr_rsp: got pulses=%0d vld=%b q=%h err=%b want 1 0001 00c3 0",
               seen, rsp_valid, rsp_q, rsp_err);
    end
  endtask

  task automatic test_onehot();
    total++;
    if (multi_hot != 0 || sb.size() != 0) begin
      bad++;
      $display("FAIL onehot_and_sb: got multi_hot=%0d leftover=%0d want 0 0",
               multi_hot, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_div_zero();
    test_timeout();
    test_drop();
    test_reset_run();
    test_onehot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one divider_22 instance.
REQ-002 Parameter TIMEOUT, default 200: maximum RUN cycles before an operation aborts.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NREQ  per-requester request; requester holds it and its operands stable until its req_ready pulse.
REQ-006 req_a  in  NREQ*22  flattened signed dividends; slice k = [22k+21:22k].
REQ-007 req_b  in  NREQ*8  flattened signed divisors; slice k = [8k+7:8k].
REQ-008 req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
REQ-009 rsp_valid  out  NREQ  one-cycle result pulse to the owning requester.
REQ-010 rsp_q, rsp_r  out  16 each  quotient and remainder, valid only while rsp_valid is non-zero.
REQ-011 rsp_err  out  1  error flag (divide-by-zero or timeout), qualified by rsp_valid.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 div_rst_n  out  1  divider clear, drives divider rst_n.
REQ-014 div_start  out  1  divider start_sig.
REQ-015 div_a, div_b  out  22, 8  divider operands.
REQ-016 div_done, div_q, div_r  in  1, 16, 16  divider done_sig, c, d.

Function
REQ-017 All outputs shall be registered; FSM states: IDLE, CLR, RUN, RESP.
REQ-018 IDLE: with any req_valid set, the round-robin winner shall be picked, its operands latched into div_a/div_b, and the FSM shall go to CLR.
REQ-019 Round-robin search shall start at (last granted + 1) mod NREQ; after reset, last granted = NREQ-1, so requester 0 has first priority.
REQ-020 CLR lasts exactly one cycle: req_ready[winner]=1, div_rst_n=0, div_start=0.
REQ-021 In CLR, if the latched divisor is 0, the FSM shall skip RUN and go to RESP with err=1, q=0, r=0.
REQ-022 Otherwise CLR shall go to RUN; RUN holds div_rst_n=1, div_start=1, operands stable, and an 8-bit counter starting at 0.
REQ-023 RUN shall exit to RESP on the first cycle div_done=1, capturing div_q/div_r, with err=0.
REQ-024 RUN shall exit to RESP with err=1, q=0, r=0 when the counter reaches TIMEOUT without div_done.
REQ-025 RESP lasts one cycle: rsp_valid[winner]=1, with rsp_q, rsp_r and rsp_err driven, div_start=0; the FSM then returns to IDLE.
REQ-026 Latency from req_ready to rsp_valid shall be RUN length + 1 cycles, or 1 cycle on divide-by-zero.
REQ-027 Requests arriving during non-IDLE states shall wait; a valid drop before its grant shall be ignored with no error.
REQ-028 Back-to-back operations shall always insert CLR, so the divider restarts from its state 0.
REQ-029 At most one bit of req_ready and one bit of rsp_valid shall be set in any cycle.
REQ-030 Outside RESP, rsp_q, rsp_r and rsp_err shall hold their last values.

Reset
REQ-031 Reset shall force IDLE, last granted = NREQ-1, counter 0, req_ready=0, rsp_valid=0, rsp_q=0, rsp_r=0, rsp_err=0, busy=0, div_start=0, div_a=0, div_b=0, and div_rst_n=0.
REQ-032 div_rst_n shall rise to 1 on the first clock after rst_n deasserts, then stay 1 except in CLR.
REQ-033 Reset mid-operation shall abort with no rsp_valid; the interrupted requester reissues.

Structure
REQ-034 Package divider_arbiter_pkg shall hold the state enum, the widths 22/8/16, and the counter width.
REQ-035 Sub-module rr_arbiter (combinational round-robin picker: request vector plus last-granted index -> one-hot grant and index) shall be instantiated once.
REQ-036 The divider shall not be instantiated inside this block; the top level connects div_* to divider_22.

Verification
REQ-037 Single request: req_valid=0001, a=100, b=5; bench divider model returns done after 10 cycles with q=0x1234, r=0x0005 -> req_ready=0001 once, rsp_valid=0001 with q=0x1234, r=0x0005, err=0, 11 cycles after req_ready.
REQ-038 Fairness: req_valid=1111 held -> grants in order 0,1,2,3,0; each CLR shows div_rst_n=0 for exactly one cycle.
REQ-039 Divide-by-zero: requester 2, b=0 -> rsp_valid=0100 one cycle after req_ready, err=1, q=0, r=0; div_start never high.
REQ-040 Timeout: model never asserts done, TIMEOUT=200 -> rsp_valid after 200 RUN cycles with err=1; next request proceeds normally.
REQ-041 Reset in RUN: rst_n low at RUN cycle 5 -> all outputs at reset values, no rsp_valid; after release, requester 0 wins first.
